// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types and constants for the step/run clock-enable controller
// and its button debouncer.
package cpu_step_ctrl_pkg;

  localparam int DEB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    DEB_RELEASE = 2'd3
  } deb_state_t;

  // Terminal count of the stable counter for a given debounce length.
  function automatic logic [DEB_CNT_W-1:0] deb_last(input int cycles);
    return DEB_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchroniser plus press/release debouncer for one board button.
// Emits a single registered step_req pulse per accepted press.
module btn_debouncer
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_async,
  output logic       step_req,
  output deb_state_t deb_state
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = deb_last(DEBOUNCE_CYCLES);
  localparam logic [DEB_CNT_W-1:0] DEB_ONE  = DEB_CNT_W'(1);

  logic                 btn_meta;
  logic                 btn_s;
  deb_state_t           state_q;
  deb_state_t           state_d;
  logic [DEB_CNT_W-1:0] deb_cnt;
  logic [DEB_CNT_W-1:0] deb_cnt_d;
  logic                 step_req_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= btn_async;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      deb_cnt  <= '0;
      step_req <= 1'b0;
    end else begin
      state_q  <= state_d;
      deb_cnt  <= deb_cnt_d;
      step_req <= step_req_d;
    end
  end

  // step_req is registered so it rises exactly DEBOUNCE_CYCLES after btn_s.
  always_comb begin
    state_d    = state_q;
    deb_cnt_d  = deb_cnt;
    step_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d   = DEB_PRESS;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_PRESS: begin
        if (!btn_s) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d    = PRESSED;
          deb_cnt_d  = '0;
          step_req_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + DEB_ONE;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_d   = DEB_RELEASE;
          deb_cnt_d = DEB_ONE;
        end
      end
      DEB_RELEASE: begin
        if (btn_s) begin
          state_d   = PRESSED;
          deb_cnt_d = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt + DEB_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  assign deb_state = state_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns the divider TICK into the core clock-enable CPU_EN, either on every
// TICK (run) or once per debounced step press (step), gated by HALT.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32
) (
  input  logic             CLK_50,
  input  logic             RESET_N,
  input  logic             TICK,
  input  logic             RUN,
  input  logic             STEP_BTN,
  input  logic             HALT,
  output logic             CPU_EN,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic             STEP_PENDING,
  output deb_state_t       DEB_STATE
);

  logic run_meta;
  logic run_s;
  logic step_req;
  logic pending;
  logic grant;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_deb (
    .clk      (CLK_50),
    .rst_n    (RESET_N),
    .btn_async(STEP_BTN),
    .step_req (step_req),
    .deb_state(DEB_STATE)
  );

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
    end else begin
      run_meta <= RUN;
      run_s    <= run_meta;
    end
  end

  // TICK/CPU_EN protocol: TICK is a one-cycle request with no back-pressure;
  // a granted TICK yields exactly one CPU_EN cycle on the following clock.
  assign grant = TICK & ~HALT & (run_s | pending);

  // A step_req landing on a grant cycle re-arms pending for the next TICK.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= 1'b0;
    end else if (run_s || HALT) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | step_req;
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      CPU_EN    <= 1'b0;
      CYCLE_CNT <= '0;
    end else begin
      CPU_EN <= grant;
      if (grant) begin
        CYCLE_CNT <= CYCLE_CNT + CNT_W'(1);
      end
    end
  end

  assign STEP_PENDING = pending;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: expected CPU_EN cycle and count
// are queued when a grant-worthy TICK is driven and popped when CPU_EN rises.
module tb_cpu_step_ctrl;
  import cpu_step_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          CLK_50   = 1'b0;
  logic          RESET_N  = 1'b0;
  logic          TICK     = 1'b0;
  logic          RUN      = 1'b0;
  logic          STEP_BTN = 1'b0;
  logic          HALT     = 1'b0;
  logic          CPU_EN;
  logic [CW-1:0] CYCLE_CNT;
  logic          STEP_PENDING;
  deb_state_t    DEB_STATE;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .CLK_50      (CLK_50),
    .RESET_N     (RESET_N),
    .TICK        (TICK),
    .RUN         (RUN),
    .STEP_BTN    (STEP_BTN),
    .HALT        (HALT),
    .CPU_EN      (CPU_EN),
    .CYCLE_CNT   (CYCLE_CNT),
    .STEP_PENDING(STEP_PENDING),
    .DEB_STATE   (DEB_STATE)
  );

  // ---------------- clock / cycle stamp ----------------
  always #10 CLK_50 = ~CLK_50;

  int cyc = 0;
  always @(posedge CLK_50) cyc++;

  // ---------------- scoreboard state ----------------
  logic [39:0] exp_q[$];  // {expected CPU_EN cycle, expected CYCLE_CNT}
  logic [39:0] mon_e;
  logic [7:0]  model_cnt = 8'd0;
  logic [7:0]  base;
  int          n_checks  = 0;
  int          n_pass    = 0;
  bit          bounce [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input bit t, input bit g);
    @(posedge CLK_50);
    #1;
    TICK = t;
    if (t && g) begin
      model_cnt = model_cnt + 8'd1;
      exp_q.push_back({32'(cyc + 1), model_cnt});
    end
  endtask

  task automatic ticks(input int n, input bit g);
    for (int i = 0; i < n; i++) drive_cycle(i % 2 == 1, g);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge CLK_50);
    #1;
    check({tag, "_q_empty"}, 40'(exp_q.size()), 40'd0);
    RESET_N  = 1'b0;
    TICK     = 1'b0;
    STEP_BTN = 1'b0;
    #1;
    check({tag, "_en"},   40'(CPU_EN),       40'd0);
    check({tag, "_cnt"},  40'(CYCLE_CNT),    40'd0);
    check({tag, "_pend"}, 40'(STEP_PENDING), 40'd0);
    check({tag, "_deb"},  40'(DEB_STATE),    40'(IDLE));
    model_cnt = 8'd0;
    exp_q.delete();
    @(posedge CLK_50);
    #1;
    RESET_N = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK_50) begin
    if (CPU_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexp_en", 40'(CPU_EN), 40'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("en_cycle", 40'(cyc), 40'(mon_e[39:8]));
        check("en_cnt", 40'(CYCLE_CNT), 40'(mon_e[7:0]));
      end
    end
  end

  // ---------------- scenarios ----------------
  initial begin
    #5;
    check("rst0_en",  40'(CPU_EN),       40'd0);
    check("rst0_cnt", 40'(CYCLE_CNT),    40'd0);
    check("rst0_pend", 40'(STEP_PENDING), 40'd0);
    do_reset("rst1");

    // 1: run mode, 10 TICKs in 20 cycles
    RUN = 1'b1;
    idle(3);
    ticks(20, 1'b1);
    idle(2);
    check("s1_cnt", 40'(CYCLE_CNT), 40'd10);

    // 2: step mode, one clean press held ~30 cycles
    RUN = 1'b0;
    idle(3);
    base = model_cnt;
    @(posedge CLK_50);
    #1;
    STEP_BTN = 1'b1;
    TICK     = 1'b0;
    idle(6);
    check("s2_pend_early", 40'(STEP_PENDING), 40'd0);
    idle(1);
    check("s2_pend_set", 40'(STEP_PENDING), 40'd1);
    check("s2_deb_pressed", 40'(DEB_STATE), 40'(PRESSED));
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0);
    check("s2_pend_clr", 40'(STEP_PENDING), 40'd0);
    ticks(22, 1'b0);
    STEP_BTN = 1'b0;
    ticks(12, 1'b0);
    check("s2_cnt", 40'(CYCLE_CNT), 40'(base + 8'd1));
    check("s2_deb_idle", 40'(DEB_STATE), 40'(IDLE));

    // 3: bouncing press never stable for DEB cycles
    base = model_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(i % 2 == 1, 1'b0);
      STEP_BTN = bounce[i];
    end
    STEP_BTN = 1'b0;
    ticks(16, 1'b0);
    check("s3_cnt", 40'(CYCLE_CNT), 40'(base));
    check("s3_pend", 40'(STEP_PENDING), 40'd0);
    check("s3_deb_idle", 40'(DEB_STATE), 40'(IDLE));

    // 4: run mode held off by HALT, first grant on first TICK after release
    base = model_cnt;
    HALT = 1'b1;
    RUN  = 1'b1;
    ticks(10, 1'b0);
    drive_cycle(1'b0, 1'b0);
    check("s4_halt_cnt", 40'(CYCLE_CNT), 40'(base));
    HALT = 1'b0;
    drive_cycle(1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1);
    idle(2);
    check("s4_cnt", 40'(CYCLE_CNT), 40'(base + 8'd2));

    // 5: counter wrap after 255 grants
    do_reset("rst2");
    idle(3);
    ticks(510, 1'b1);
    idle(2);
    check("s5_cnt255", 40'(CYCLE_CNT), 40'd255);
    drive_cycle(1'b1, 1'b1);
    idle(2);
    check("s5_wrap", 40'(CYCLE_CNT), 40'd0);

    // 6: reset while a step is pending
    ticks(8, 1'b1);
    RUN = 1'b0;
    idle(3);
    drive_cycle(1'b0, 1'b0);
    STEP_BTN = 1'b1;
    idle(8);
    check("s6_pend_set", 40'(STEP_PENDING), 40'd1);
    check("s6_cnt_pre", 40'(CYCLE_CNT), 40'd4);
    do_reset("rst3");
    ticks(12, 1'b0);
    check("s6_cnt", 40'(CYCLE_CNT), 40'd0);
    check("s6_pend", 40'(STEP_PENDING), 40'd0);

    check("final_q_empty", 40'(exp_q.size()), 40'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Sits directly downstream of the clock divider that turns CLK_50 into the one-cycle TICK pulse. Turns TICK into the processor's clock-enable CPU_EN, in one of two modes:
- **Run mode:** CPU_EN follows every TICK.
- **Step mode:** one CPU_EN per debounced press of the board's step button.

It also honours a HALT request from the core and counts issued cycles for the board display.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change; legal range 2..65535.
- CNT_W, 32: width of CYCLE_CNT.

Ports:
- CLK_50  in  1  system clock; the only clock.
- RESET_N  in  1  reset, asynchronous assert, active-low.
- TICK  in  1  one-cycle pulse from the divider, synchronous to CLK_50.
- RUN  in  1  board switch, asynchronous: 1 = run mode, 0 = step mode.
- STEP_BTN  in  1  board push-button, asynchronous, active-high, bouncy.
- HALT  in  1  from the core, synchronous level; while 1, no enables are issued.
- CPU_EN  out  1  registered clock-enable pulse to the core.
- CYCLE_CNT  out  CNT_W  number of CPU_EN pulses issued since reset; wraps modulo 2^CNT_W.
- STEP_PENDING  out  1  a debounced step press is waiting for a TICK.

## Operation
- **Synchronisers:** RUN and STEP_BTN each pass through a 2-flop synchroniser. The synchronised values are run_s and btn_s.
- **Debouncer FSM** on btn_s. It has a 16-bit stable counter, deb_cnt.
  - IDLE: if btn_s=1, go to DEB_PRESS with deb_cnt=1.
  - DEB_PRESS: if btn_s=0, return to IDLE. If deb_cnt==DEBOUNCE_CYCLES-1, go to PRESSED and pulse step_req for one cycle. Otherwise increment deb_cnt.
  - PRESSED: if btn_s=0, go to DEB_RELEASE with deb_cnt=1.
  - DEB_RELEASE: if btn_s=1, return to PRESSED. If deb_cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise increment deb_cnt.
  - Net effect: exactly one step_req per accepted press, however long the button is held.
- **Pending flag:**
  - Update: pending <= run_s ? 0 : HALT ? 0 : ((pending & ~grant) | step_req).
  - A step_req arriving in the same cycle as a grant re-arms pending.
  - STEP_PENDING = pending.
- **Grant:** grant = TICK & ~HALT & (run_s | pending).
- **Outputs:** CPU_EN <= grant. When grant=1, CYCLE_CNT <= CYCLE_CNT+1, wrapping from all-ones to 0.
- **Mode change:** a RUN change takes effect through the synchroniser. Any pending step is discarded on entry to run mode.
- **HALT:** blocks grants in both modes and clears pending. Presses made while HALT=1 are lost.

## Timing
- **Reset values:** CPU_EN=0, CYCLE_CNT=0, STEP_PENDING=0. Debouncer in IDLE, deb_cnt=0, synchroniser flops at 0.
- **Reset mid-operation:** everything returns to reset values immediately (asynchronous). Release is synchronous to CLK_50 through normal flops; no partial step is issued.
- **CPU_EN latency:** CPU_EN is high exactly one cycle, the cycle after TICK=1 with the grant conditions true. Back-to-back TICKs give back-to-back CPU_EN.
- **Step latency:**
  - STEP_BTN rise to step_req: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles.
  - step_req to STEP_PENDING=1: 1 cycle.
  - STEP_PENDING to CPU_EN: next TICK + 1 cycle.
- **Glitch rejection:** a press shorter than DEBOUNCE_CYCLES stable cycles produces no step.
- **Simultaneous events:** TICK coincident with HALT=1 gives no CPU_EN and no count. TICK coincident with step_req does not grant, because pending is not yet set.

## Structure
- Shared package cpu_step_ctrl_pkg holds:
  - the deb_state_t enum (IDLE, DEB_PRESS, PRESSED, DEB_RELEASE);
  - DEB_CNT_W = 16.
- Sub-module btn_debouncer: synchroniser plus debouncer FSM, producing btn_s and step_req. It is instantiated once and is reusable for other board buttons.
- RUN synchroniser, pending flag, grant logic and counter live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=8, and TICK high every 2nd cycle (0,1,0,1...).
1. Reset, then RUN=1 for 20 cycles -> CPU_EN pulses on 10 alternate cycles, each one cycle after TICK; CYCLE_CNT=10.
2. RUN=0 with a clean STEP_BTN press held 30 cycles -> exactly one CPU_EN; CYCLE_CNT increments by 1; STEP_PENDING high from step_req+1 until the grant cycle.
3. RUN=0 with STEP_BTN bouncing 1,0,1,1,0 (never 4 stable cycles) then low -> no step_req, no CPU_EN, CYCLE_CNT unchanged.
4. RUN=1 with HALT=1 for 10 cycles, then HALT=0 -> no CPU_EN while halted; first CPU_EN follows the first TICK after HALT falls.
5. Preload CYCLE_CNT to 255 via 255 run-mode grants, then one more TICK -> CYCLE_CNT=0 with CPU_EN=1.
6. Mid-run, RESET_N low for 1 cycle while STEP_PENDING=1 -> all outputs 0 immediately; no CPU_EN on the next TICK in step mode.
